// File: rtl/unrom_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : unrom_bank_ctrl
// Brief    : UNROM PRG bank controller. It samples the asynchronous CPU
//            cartridge bus on a fast system clock, accepts completed
//            $8000-$FFFF write cycles, and loads a 4-bit bank register.
//            Optional bus-conflict emulation ANDs the CPU data with the ROM
//            data. The block drives PRG A17..A14: the switchable bank in the
//            low 16 KiB and bank 15 fixed in the high 16 KiB.
// Revision : 1.0 - initial release
// ============================================================================
module unrom_bank_ctrl #(
  parameter int SYNC_STAGES  = 2,  // synchronizer depth, 2..4
  parameter int MIN_LOW      = 3,  // minimum synchronized low clocks, 1..15
  parameter int CONFLICT_EMU = 1   // 1: store cpu_d & prg_d, 0: store cpu_d
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cpu_d,
  input  logic       cpu_rw,
  input  logic       Ncpu_romsel,
  input  logic       cpu_a14,
  input  logic [3:0] prg_d,
  output logic [3:0] prg_a,
  output logic [3:0] bank,
  output logic       bank_wr
);

  // Synchronizer word layout: {valid, romsel, rw, d[3:0], pd[3:0]}.
  // The valid bit is 0 in every reset stage and 1 for every real pin sample.
  // It tells a genuine idle-high romsel apart from the reset fill value.
  localparam int         C_SW        = 11;
  localparam logic [C_SW-1:0] C_SYNC_RST = {1'b0, 1'b1, 1'b1, 4'h0, 4'h0};
  localparam logic [3:0] C_MIN_LOW   = 4'(MIN_LOW);
  localparam logic [3:0] C_CNT_MAX   = 4'hF;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_LOW  = 1'b1
  } state_t;

  // ------------------------------------------------------------------------
  // Input synchronizer: one shared pipeline keeps all bus bits aligned.
  // ------------------------------------------------------------------------
  logic [C_SW-1:0] sync_q [SYNC_STAGES];
  logic [C_SW-1:0] sync_d [SYNC_STAGES];

  // Next value of each stage: stage 0 takes the pins, later stages shift.
  always_comb begin
    sync_d[0] = {1'b1, Ncpu_romsel, cpu_rw, cpu_d, prg_d};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Synchronizer flops. Reset fills them with an idle bus marked not valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= C_SYNC_RST;
      end
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  logic       valid_s;
  logic       romsel_s;
  logic       rw_s;
  logic [3:0] d_s;
  logic [3:0] pd_s;

  assign {valid_s, romsel_s, rw_s, d_s, pd_s} = sync_q[SYNC_STAGES-1];

  // ------------------------------------------------------------------------
  // Capture source: raw CPU data or the bus-conflict AND with ROM data.
  // ------------------------------------------------------------------------
  logic [3:0] cap_src;

  if (CONFLICT_EMU != 0) begin : g_conflict
    assign cap_src = d_s & pd_s;
  end else begin : g_no_conflict
    assign cap_src = d_s;
  end

  // ------------------------------------------------------------------------
  // Edge detect and controller state
  // ------------------------------------------------------------------------
  state_t     state_q,   state_d;
  logic       romsel_q,  romsel_d;
  logic       armed_q,   armed_d;
  logic [3:0] low_cnt_q, low_cnt_d;
  logic [3:0] cap_q,     cap_d;
  logic       rw_last_q, rw_last_d;
  logic [3:0] bank_q,    bank_d;
  logic       bank_wr_q, bank_wr_d;

  logic       fall;
  logic       rise;

  assign fall = romsel_q & ~romsel_s;
  assign rise = ~romsel_q & romsel_s;

  // Edge history and arming. A cycle may start only after a real high romsel
  // sample, so a low window that straddles reset cannot be picked up half-way.
  always_comb begin
    romsel_d = romsel_s;
    armed_d  = armed_q | (valid_s & romsel_s);
  end

  // Next-state logic: follow one ROM-select low window and decide whether to
  // load the bank.
  always_comb begin
    state_d   = state_q;
    low_cnt_d = low_cnt_q;
    cap_d     = cap_q;
    rw_last_d = rw_last_q;
    bank_d    = bank_q;
    bank_wr_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fall && armed_q) begin
          state_d   = S_LOW;
          low_cnt_d = 4'd1;
          cap_d     = cap_src;
          rw_last_d = rw_s;
        end
      end

      S_LOW: begin
        if (!romsel_s) begin
          // Keep counting, and keep re-sampling so the last low sample wins.
          if (low_cnt_q != C_CNT_MAX) begin
            low_cnt_d = low_cnt_q + 4'd1;
          end
          cap_d     = cap_src;
          rw_last_d = rw_s;
        end else if (rise) begin
          // Cycle finished: load only long-enough write cycles.
          if ((low_cnt_q >= C_MIN_LOW) && !rw_last_q) begin
            bank_d    = cap_q;
            bank_wr_d = 1'b1;
          end
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Controller registers. Reset aborts any window in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      romsel_q  <= 1'b1;
      armed_q   <= 1'b0;
      low_cnt_q <= 4'd0;
      cap_q     <= 4'd0;
      rw_last_q <= 1'b1;
      bank_q    <= 4'd0;
      bank_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      romsel_q  <= romsel_d;
      armed_q   <= armed_d;
      low_cnt_q <= low_cnt_d;
      cap_q     <= cap_d;
      rw_last_q <= rw_last_d;
      bank_q    <= bank_d;
      bank_wr_q <= bank_wr_d;
    end
  end

  // ------------------------------------------------------------------------
  // Outputs: the address map is purely combinational on cpu_a14.
  // ------------------------------------------------------------------------
  assign bank    = bank_q;
  assign bank_wr = bank_wr_q;
  assign prg_a   = cpu_a14 ? 4'hF : bank_q;

endmodule
`default_nettype wire

// File: tb/tb_unrom_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_unrom_bank_ctrl
// Brief    : Scoreboard bench for unrom_bank_ctrl. Two instances share one
//            stimulus bus, one without and one with bus-conflict emulation.
//            Bus cycles are modelled as whole transactions: an accepted write
//            queues its stored value and the clock on which it must appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unrom_bank_ctrl;

  localparam int SYNC_STAGES = 2;
  localparam int MIN_LOW     = 3;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic [3:0] cpu_d  = 4'h0;
  logic [3:0] prg_d  = 4'h0;
  logic       cpu_rw = 1'b1;
  logic       romsel = 1'b1;
  logic       a14    = 1'b0;
  logic       rand_a14 = 1'b0;

  logic [3:0] prg_a0, bank0, prg_a1, bank1;
  logic       wr0, wr1;

  unrom_bank_ctrl #(.SYNC_STAGES(SYNC_STAGES), .MIN_LOW(MIN_LOW), .CONFLICT_EMU(0)) dut0 (
    .clk(clk), .rst(rst), .cpu_d(cpu_d), .cpu_rw(cpu_rw), .Ncpu_romsel(romsel),
    .cpu_a14(a14), .prg_d(prg_d), .prg_a(prg_a0), .bank(bank0), .bank_wr(wr0)
  );

  unrom_bank_ctrl #(.SYNC_STAGES(SYNC_STAGES), .MIN_LOW(MIN_LOW), .CONFLICT_EMU(1)) dut1 (
    .clk(clk), .rst(rst), .cpu_d(cpu_d), .cpu_rw(cpu_rw), .Ncpu_romsel(romsel),
    .cpu_a14(a14), .prg_d(prg_d), .prg_a(prg_a1), .bank(bank1), .bank_wr(wr1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] val;
    int         at;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  logic [3:0] exp_bank0 = 4'h0;
  logic [3:0] exp_bank1 = 4'h0;

  int errors = 0;
  int checks = 0;

  function automatic void check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor, non-conflict instance
  always @(negedge clk) begin
    if (rst) begin
      exp_bank0 = 4'h0;
    end else begin
      if (wr0) begin
        if (q0.size() == 0) begin
          check("dut0 unexpected bank_wr", 1, 0);
        end else begin
          e0 = q0.pop_front();
          check("dut0 bank_wr timing", cyc, e0.at);
          check("dut0 loaded value", int'(bank0), int'(e0.val));
          exp_bank0 = e0.val;
        end
      end else if (q0.size() != 0 && q0[0].at < cyc) begin
        check("dut0 missing bank_wr", 0, 1);
        e0 = q0.pop_front();
      end
      check("dut0 bank", int'(bank0), int'(exp_bank0));
      check("dut0 prg_a", int'(prg_a0), a14 ? 15 : int'(exp_bank0));
    end
  end

  // Monitor, conflict-emulating instance
  always @(negedge clk) begin
    if (rst) begin
      exp_bank1 = 4'h0;
    end else begin
      if (wr1) begin
        if (q1.size() == 0) begin
          check("dut1 unexpected bank_wr", 1, 0);
        end else begin
          e1 = q1.pop_front();
          check("dut1 bank_wr timing", cyc, e1.at);
          check("dut1 loaded value", int'(bank1), int'(e1.val));
          exp_bank1 = e1.val;
        end
      end else if (q1.size() != 0 && q1[0].at < cyc) begin
        check("dut1 missing bank_wr", 0, 1);
        e1 = q1.pop_front();
      end
      check("dut1 bank", int'(bank1), int'(exp_bank1));
      check("dut1 prg_a", int'(prg_a1), a14 ? 15 : int'(exp_bank1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_a14) a14 = 1'($urandom_range(0, 1));
  endtask

  // One CPU bus cycle: romsel low for 'low' clocks, then high for 'gap' clocks.
  // A reset pulse may be injected after low clock number rst_at (-1 = none).
  task automatic bus_cycle(input logic rw, input logic [3:0] d, input logic [3:0] pd,
                           input int low, input int gap, input int rst_at);
    int   c;
    exp_t x;
    if (rst_at >= 0) repeat (SYNC_STAGES + 3) tick();
    cpu_rw = rw;
    cpu_d  = d;
    prg_d  = pd;
    romsel = 1'b0;
    for (int i = 0; i < low; i++) begin
      tick();
      if (i == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
    end
    romsel = 1'b1;
    c = cyc;
    if (rst_at < 0 && !rw && low >= MIN_LOW) begin
      x.at  = c + SYNC_STAGES + 1;
      x.val = d;
      q0.push_back(x);
      x.val = d & pd;
      q1.push_back(x);
    end
    for (int i = 0; i < gap; i++) begin
      tick();
      cpu_d  = 4'($urandom_range(0, 15));
      prg_d  = 4'($urandom_range(0, 15));
      cpu_rw = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    int low, gap, ra;
    logic rw;

    // Reset and address map
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset bank", int'(bank0), 0);
    check("reset prg_a", int'(prg_a0), 0);
    check("reset bank_wr", int'(wr0), 0);
    check("reset bank conflict inst", int'(bank1), 0);
    a14 = 1'b1;
    #1;
    check("reset prg_a a14=1", int'(prg_a0), 15);
    a14 = 1'b0;
    repeat (4) tick();

    // Basic write, then the low-bank mapping
    bus_cycle(1'b0, 4'h6, 4'hF, 8, 6, -1);
    check("basic write bank", int'(bank0), 6);
    check("basic write prg_a", int'(prg_a0), 6);

    // Read cycle leaves the bank alone
    bus_cycle(1'b1, 4'h3, 4'hF, 8, 6, -1);
    check("read cycle bank", int'(bank0), 6);

    // Bus conflicts
    bus_cycle(1'b0, 4'hF, 4'h5, 8, 6, -1);
    check("conflict F&5", int'(bank1), 5);
    check("no-conflict F", int'(bank0), 15);
    bus_cycle(1'b0, 4'h9, 4'hF, 8, 6, -1);
    check("conflict 9&F", int'(bank1), 9);

    // Glitches below MIN_LOW, then exactly MIN_LOW
    bus_cycle(1'b0, 4'hA, 4'hF, 1, 6, -1);
    check("glitch 1 ignored", int'(bank0), 9);
    bus_cycle(1'b0, 4'hA, 4'hF, 2, 6, -1);
    check("glitch 2 ignored", int'(bank0), 9);
    bus_cycle(1'b0, 4'hA, 4'hF, 3, 6, -1);
    check("min-low write", int'(bank0), 10);

    // Reset in the middle of a write window
    bus_cycle(1'b0, 4'h7, 4'hF, 8, 6, 3);
    check("reset mid-write bank", int'(bank0), 0);
    check("reset mid-write bank conflict inst", int'(bank1), 0);
    bus_cycle(1'b0, 4'h2, 4'hF, 8, 6, -1);
    check("write after reset", int'(bank0), 2);

    // Long window exercises counter saturation
    bus_cycle(1'b0, 4'hC, 4'hE, 20, 4, -1);

    // Randomized traffic with a14 toggling and occasional resets
    rand_a14 = 1'b1;
    for (int n = 0; n < 300; n++) begin
      rw  = ($urandom_range(0, 3) == 0);
      low = $urandom_range(1, 18);
      gap = $urandom_range(1, 5);
      ra  = ($urandom_range(0, 40) == 0) ? $urandom_range(0, low - 1) : -1;
      bus_cycle(rw, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), low, gap, ra);
    end
    rand_a14 = 1'b0;

    repeat (SYNC_STAGES + 5) tick();
    check("dut0 queue drained", q0.size(), 0);
    check("dut1 queue drained", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
